dfd_trace_collector: RTL and testbench

//  Parametrised DfD trace aggregator for the router. Collects SRC_NUM trigger/trace pairs
//  (inout ports, VC/SW allocator, crossbar, ...), arbitrates one per cycle, and stores tagged

---
 rtl/dfd_trace_collector_if.sv | 13 +
 rtl/dfd_trace_collector.sv | 106 ++++++++++
 tb/tb_dfd_trace_collector.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dfd_trace_collector_if.sv
// Trace output stream of the DfD collector: FIFO head word and source id, with a valid/ready handshake.
interface dfd_trace_collector_if #(
    parameter int TRACEw = 32,
    parameter int SRCw   = 2
) ();
    logic              trace_out_valid;
    logic              trace_out_ready;
    logic [TRACEw-1:0] trace_out;
    logic [SRCw-1:0]   trace_src;

    modport master (output trace_out_valid, output trace_out, output trace_src, input trace_out_ready);
    modport slave  (input trace_out_valid, input trace_out, input trace_src, output trace_out_ready);
endinterface

// File: rtl/dfd_trace_collector.sv
// DfD trace aggregator: arbitrates SRC_NUM trigger/trace sources into a tagged FIFO,
// gated by an arm/capture/freeze window, and counts trace words that were lost.
module dfd_trace_collector #(
    parameter int    SRC_NUM   = 3,
    parameter int    TRACEw    = 32,
    parameter int    DEPTH     = 16,
    parameter string ARB_MODE  = "PRIORITY",
    parameter int    POST_TRIG = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arm,
    input  logic [SRC_NUM-1:0]        trigger_in,
    input  logic [SRC_NUM*TRACEw-1:0] trace_in,
    dfd_trace_collector_if.master     out_if,
    output logic [1:0]                fsm_state,
    output logic [15:0]               drop_cnt,
    output logic                      trigger_any
);
    localparam int SRCw = (SRC_NUM > 2) ? $clog2(SRC_NUM) : 1;
    localparam int AW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam bit RRA  = (ARB_MODE == "RRA");

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] FROZEN  = 2'd3;

    logic [1:0]             state;
    logic [15:0]            cap_cnt;
    logic [SRCw-1:0]        rr_ptr;
    logic [SRCw+TRACEw-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;

    logic                   capturing, full, valid, pop, wr_en;
    logic [SRCw-1:0]        grant;
    logic [16:0]            drop_sum;
    logic [15:0]            cap_next;
    int unsigned            n_trig;

    assign capturing = (state == ARMED) || (state == CAPTURE);
    assign full      = (count == (AW+1)'(DEPTH));
    assign valid     = (count != '0);
    assign pop       = valid && out_if.trace_out_ready;
    assign wr_en     = !arm && capturing && (|trigger_in) && (!full || pop);
    assign cap_next  = cap_cnt + 16'd1;

    // RRA searches from rr_ptr with wrap; PRIORITY is the same search anchored at 0.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant  = '0;
        found  = 1'b0;
        n_trig = 0;
        for (int unsigned k = 0; k < SRC_NUM; k++) begin
            idx = RRA ? int'(rr_ptr) + k : k;
            if (idx >= SRC_NUM) idx = idx - SRC_NUM;
            if (!found && trigger_in[idx]) begin
                grant = SRCw'(idx);
                found = 1'b1;
            end
            if (trigger_in[k]) n_trig = n_trig + 1;
        end
        drop_sum = {1'b0, drop_cnt} + 17'(n_trig) - 17'(wr_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cap_cnt     <= '0;
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            drop_cnt    <= '0;
            trigger_any <= 1'b0;
        end else begin
            trigger_any <= |trigger_in;
            if (arm) begin
                state   <= ARMED;
                cap_cnt <= '0;
            end else if (wr_en) begin
                if (POST_TRIG != 0) cap_cnt <= cap_next;
                state <= (POST_TRIG != 0 && cap_next == 16'(POST_TRIG)) ? FROZEN : CAPTURE;
            end
            if (wr_en && RRA)
                rr_ptr <= (int'(grant) == SRC_NUM - 1) ? '0 : grant + 1'b1;
            if (!arm && capturing)
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (!wr_en && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {grant, trace_in[int'(grant)*TRACEw +: TRACEw]};
    end

    assign fsm_state              = state;
    assign out_if.trace_out_valid = valid;
    assign out_if.trace_out       = valid ? mem[rd_ptr][TRACEw-1:0] : '0;
    assign out_if.trace_src       = valid ? mem[rd_ptr][SRCw+TRACEw-1:TRACEw] : '0;
endmodule

// File: tb/tb_dfd_trace_collector.sv
// Scoreboard bench for dfd_trace_collector: three configurations, expected words queued by stimulus.
module tb_dfd_trace_collector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A: PRIORITY, DEPTH 16, POST_TRIG 8
    logic rstA, armA; logic [2:0] trigA; logic [95:0] traceA;
    logic [1:0] stA; logic [15:0] dropA; logic anyA;
    dfd_trace_collector_if #(.TRACEw(32), .SRCw(2)) ifA ();
    dfd_trace_collector #(.SRC_NUM(3), .TRACEw(32), .DEPTH(16), .ARB_MODE("PRIORITY"), .POST_TRIG(8)) dutA (
        .clk(clk), .reset(rstA), .arm(armA), .trigger_in(trigA), .trace_in(traceA),
        .out_if(ifA), .fsm_state(stA), .drop_cnt(dropA), .trigger_any(anyA));

    // B: RRA, DEPTH 16, POST_TRIG 0
    logic rstB, armB; logic [2:0] trigB; logic [95:0] traceB;
    logic [1:0] stB; logic [15:0] dropB; logic anyB;
    dfd_trace_collector_if #(.TRACEw(32), .SRCw(2)) ifB ();
    dfd_trace_collector #(.SRC_NUM(3), .TRACEw(32), .DEPTH(16), .ARB_MODE("RRA"), .POST_TRIG(0)) dutB (
        .clk(clk), .reset(rstB), .arm(armB), .trigger_in(trigB), .trace_in(traceB),
        .out_if(ifB), .fsm_state(stB), .drop_cnt(dropB), .trigger_any(anyB));

    // C: PRIORITY, DEPTH 4, POST_TRIG 0
    logic rstC, armC; logic [2:0] trigC; logic [95:0] traceC;
    logic [1:0] stC; logic [15:0] dropC; logic anyC;
    dfd_trace_collector_if #(.TRACEw(32), .SRCw(2)) ifC ();
    dfd_trace_collector #(.SRC_NUM(3), .TRACEw(32), .DEPTH(4), .ARB_MODE("PRIORITY"), .POST_TRIG(0)) dutC (
        .clk(clk), .reset(rstC), .arm(armC), .trigger_in(trigC), .trace_in(traceC),
        .out_if(ifC), .fsm_state(stC), .drop_cnt(dropC), .trigger_any(anyC));

    logic [33:0] qA[$], qB[$], qC[$];

    // Monitors: a handshake seen at the negedge is the pop taken at the next posedge.
    always @(negedge clk) begin
        if (!rstA && ifA.trace_out_valid && ifA.trace_out_ready) begin
            if (qA.size() == 0) begin
                total++; bad++;
                $display("FAIL monA_unexpected: got %0h expected none", {ifA.trace_src, ifA.trace_out});
            end else chk("monA_word", {ifA.trace_src, ifA.trace_out}, qA.pop_front());
        end
        if (!rstB && ifB.trace_out_valid && ifB.trace_out_ready) begin
            if (qB.size() == 0) begin
                total++; bad++;
                $display("FAIL monB_unexpected: got %0h expected none", {ifB.trace_src, ifB.trace_out});
            end else chk("monB_word", {ifB.trace_src, ifB.trace_out}, qB.pop_front());
        end
        if (!rstC && ifC.trace_out_valid && ifC.trace_out_ready) begin
            if (qC.size() == 0) begin
                total++; bad++;
                $display("FAIL monC_unexpected: got %0h expected none", {ifC.trace_src, ifC.trace_out});
            end else chk("monC_word", {ifC.trace_src, ifC.trace_out}, qC.pop_front());
        end
    end

    initial begin
        logic [31:0] w;
        int unsigned n;
        rstA = 1; rstB = 1; rstC = 1;
        armA = 0; armB = 0; armC = 0;
        trigA = '0; trigB = '0; trigC = '0;
        traceA = '0; traceB = '0; traceC = '0;
        ifA.trace_out_ready = 1; ifB.trace_out_ready = 1; ifC.trace_out_ready = 0;
        step(); step();
        rstA = 0; rstB = 0; rstC = 0;

        chk("rst_state", stA, 2'd0);
        chk("rst_valid", ifA.trace_out_valid, 1'b0);
        chk("rst_out", {ifA.trace_src, ifA.trace_out}, 34'h0);
        chk("rst_drop", dropA, 16'd0);
        chk("rst_any", anyA, 1'b0);

        // 1: single cycle trigger 101 under PRIORITY
        armA = 1; step(); armA = 0;
        chk("t1_armed", stA, 2'd1);
        traceA = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        trigA = 3'b101;
        qA.push_back({2'd0, 32'hAAAA_0000});
        step(); trigA = '0;
        chk("t1_capture", stA, 2'd2);
        chk("t1_drop", dropA, 16'd1);
        chk("t1_any", anyA, 1'b1);
        step();
        chk("t1_any_clr", anyA, 1'b0);

        // 2: RRA with all three sources held for six cycles
        armB = 1; step(); armB = 0;
        trigB = 3'b111;
        for (int c = 0; c < 6; c++) begin
            w = 32'hB000_0000 + 32'(c * 16);
            traceB = {w + 32'd2, w + 32'd1, w};
            qB.push_back({2'(c % 3), w + 32'(c % 3)});
            step();
        end
        trigB = '0;
        chk("t2_drop", dropB, 16'd12);
        chk("t2_state", stB, 2'd2);

        // 4: continuous trigger closes the window after 8 words
        armA = 1; step(); armA = 0;
        trigA = 3'b010;
        for (int k = 0; k < 12; k++) begin
            w = 32'h4000_0000 + 32'(k);
            traceA = {32'h0, w, 32'h0};
            if (k < 8) qA.push_back({2'd1, w});
            step();
        end
        chk("t4_frozen", stA, 2'd3);
        chk("t4_drop", dropA, 16'd1);
        trigA = '0;
        armA = 1; step(); armA = 0;
        chk("t4_rearm", stA, 2'd1);

        // 3: DEPTH 4, consumer stalled, six single-source triggers
        armC = 1; step(); armC = 0;
        trigC = 3'b100;
        for (int k = 0; k < 6; k++) begin
            w = 32'hC000_0000 + 32'(k);
            traceC = {w, 32'h0, 32'h0};
            if (k < 4) qC.push_back({2'd2, w});
            step();
        end
        trigC = '0;
        chk("t3_drop", dropC, 16'd2);
        chk("t3_valid", ifC.trace_out_valid, 1'b1);
        chk("t3_head", {ifC.trace_src, ifC.trace_out}, {2'd2, 32'hC000_0000});

        // 5: full FIFO with pop and push in the same cycle
        ifC.trace_out_ready = 1;
        trigC = 3'b100; traceC = {32'hC000_0010, 64'h0};
        qC.push_back({2'd2, 32'hC000_0010});
        step();
        ifC.trace_out_ready = 0; trigC = '0;
        chk("t5_drop", dropC, 16'd2);
        trigC = 3'b100; traceC = {32'hDEAD_BEEF, 64'h0};
        step(); trigC = '0;
        chk("t5_still_full", dropC, 16'd3);
        ifC.trace_out_ready = 1;
        n = 0;
        while (ifC.trace_out_valid && n < 20) begin step(); n++; end
        chk("t3_drained", ifC.trace_out_valid, 1'b0);
        chk("t3_drain_cycles", n, 4);

        // 6: reset with words queued
        ifA.trace_out_ready = 0;
        step();
        trigA = 3'b001;
        for (int k = 0; k < 3; k++) begin
            traceA = {64'h0, 32'h6000_0000 + 32'(k)};
            step();
        end
        trigA = '0;
        chk("t6_valid_pre", ifA.trace_out_valid, 1'b1);
        chk("t6_drop_pre", dropA, 16'd1);
        rstA = 1; step(); rstA = 0;
        chk("t6_valid", ifA.trace_out_valid, 1'b0);
        chk("t6_state", stA, 2'd0);
        chk("t6_drop", dropA, 16'd0);
        ifA.trace_out_ready = 1;

        step(); step();
        chk("qA_empty", qA.size(), 0);
        chk("qB_empty", qB.size(), 0);
        chk("qC_empty", qC.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
